// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl -- frequency-sweep sequencer for the sine DDS path
//   (phase-address generator -> 1-cycle sine ROM -> dds_en output gate).
//
// Sequence: IDLE -> CLEAR (phase clear) -> SETTLE (pipeline fill, dds_en low)
//           -> DWELL (step freq_word from start to stop, cfg_dwell+1 cycles
//           per word, cfg_sweeps sweeps) -> FINISH (done pulse) -> IDLE.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, abort         control handshake (abort has priority)
//   cfg_f_start/stop/step, cfg_dwell, cfg_sweeps
//                        sweep configuration, latched when start is accepted
//   freq_word            tuning word to the DDS phase accumulator
//   phase_clr            one-cycle phase-accumulator clear
//   dds_en               DDS output enable
//   busy, done           status: busy outside IDLE, done pulses on completion
//   sweep_idx            completed sweeps in the current run
//
// Optional feature macro: DDS_SWEEP_PINGPONG_EN
//   Defined   : sweep direction alternates up/down at every sweep end; each
//               leg counts as one sweep.
//   Undefined : sawtooth sweeps, every sweep restarts at cfg_f_start.
module dds_sweep_ctrl #(
   parameter int FW     = 32,
   parameter int DW     = 16,
   parameter int CW     = 8,
   parameter int SETTLE = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   input  logic [FW-1:0] cfg_f_start,
   input  logic [FW-1:0] cfg_f_stop,
   input  logic [FW-1:0] cfg_f_step,
   input  logic [DW-1:0] cfg_dwell,
   input  logic [CW-1:0] cfg_sweeps,
   output logic [FW-1:0] freq_word,
   output logic          phase_clr,
   output logic          dds_en,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] sweep_idx
);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_SETTLE, S_DWELL, S_FINISH
   } state_t;

   state_t        state, nxt_state;
   logic [FW-1:0] nxt_fw;
   logic          nxt_pclr, nxt_en, nxt_busy, nxt_done;
   logic [CW-1:0] nxt_idx;
   logic [DW-1:0] dwell_cnt, nxt_dcnt;
   logic [3:0]    settle_cnt, nxt_scnt;

   // configuration snapshot taken at start acceptance
   logic [FW-1:0] c_start, c_stop, c_step;
   logic [DW-1:0] c_dwell;
   logic [CW-1:0] c_sweeps;

   logic          accept;
   logic [FW:0]   up_sum;
   logic          up_end;
   logic [CW-1:0] sweep_inc;
   logic          last_sweep;

   assign accept     = (state == S_IDLE) && start && !abort;
   // one extra bit so a wrap past 2^FW ends the sweep instead of restarting low
   assign up_sum     = {1'b0, freq_word} + {1'b0, c_step};
   // a zero step would never reach stop; treat it as a one-word sweep
   assign up_end     = up_sum[FW] || (up_sum[FW-1:0] > c_stop) || (c_step == '0);
   assign sweep_inc  = sweep_idx + 1'b1;
   assign last_sweep = (c_sweeps != '0) && (sweep_inc == c_sweeps);

`ifdef DDS_SWEEP_PINGPONG_EN
   logic          dir, nxt_dir;   // 0 = up leg, 1 = down leg
   logic [FW:0]   dn_diff;
   logic          dn_end;

   assign dn_diff = {1'b0, freq_word} - {1'b0, c_step};
   assign dn_end  = dn_diff[FW] || (dn_diff[FW-1:0] < c_start) || (c_step == '0);
`endif

   always_comb begin
      nxt_state = state;
      nxt_fw    = freq_word;
      nxt_pclr  = 1'b0;
      nxt_en    = dds_en;
      nxt_busy  = busy;
      nxt_done  = 1'b0;
      nxt_idx   = sweep_idx;
      nxt_dcnt  = dwell_cnt;
      nxt_scnt  = settle_cnt;
`ifdef DDS_SWEEP_PINGPONG_EN
      nxt_dir   = dir;
`endif
      case (state)
         S_IDLE: begin
            nxt_fw = '0;
            nxt_en = 1'b0;
            if (accept) begin
               nxt_state = S_CLEAR;
               nxt_fw    = cfg_f_start;
               nxt_pclr  = 1'b1;
               nxt_busy  = 1'b1;
               nxt_idx   = '0;
`ifdef DDS_SWEEP_PINGPONG_EN
               nxt_dir   = 1'b0;
`endif
            end
         end
         S_CLEAR: begin
            nxt_state = S_SETTLE;
            nxt_scnt  = '0;
         end
         S_SETTLE: begin
            if (settle_cnt == 4'(SETTLE - 1)) begin
               nxt_state = S_DWELL;
               nxt_en    = 1'b1;
               nxt_dcnt  = '0;
            end else begin
               nxt_scnt  = settle_cnt + 1'b1;
            end
         end
         S_DWELL: begin
            if (dwell_cnt == c_dwell) begin
               nxt_dcnt = '0;
`ifdef DDS_SWEEP_PINGPONG_EN
               if (!(dir ? dn_end : up_end)) begin
                  nxt_fw = dir ? dn_diff[FW-1:0] : up_sum[FW-1:0];
               end else begin
                  nxt_idx = sweep_inc;
                  if (last_sweep) begin
                     nxt_state = S_FINISH;
                     nxt_done  = 1'b1;
                     nxt_en    = 1'b0;
                  end else begin
                     // reverse: first word of the new leg is one step back
                     nxt_dir = !dir;
                     nxt_fw  = dir ? up_sum[FW-1:0] : dn_diff[FW-1:0];
                  end
               end
`else
               if (!up_end) begin
                  nxt_fw = up_sum[FW-1:0];
               end else begin
                  nxt_idx = sweep_inc;
                  if (last_sweep) begin
                     nxt_state = S_FINISH;
                     nxt_done  = 1'b1;
                     nxt_en    = 1'b0;
                  end else begin
                     nxt_fw = c_start;   // no phase clear between sweeps
                  end
               end
`endif
            end else begin
               nxt_dcnt = dwell_cnt + 1'b1;
            end
         end
         S_FINISH: begin
            nxt_state = S_IDLE;
            nxt_fw    = '0;
            nxt_busy  = 1'b0;
         end
         default: begin
            nxt_state = S_IDLE;
            nxt_fw    = '0;
            nxt_en    = 1'b0;
            nxt_busy  = 1'b0;
         end
      endcase
      // abort wins over everything outside IDLE; sweep_idx is left as is
      if (state != S_IDLE && abort) begin
         nxt_state = S_IDLE;
         nxt_fw    = '0;
         nxt_pclr  = 1'b0;
         nxt_en    = 1'b0;
         nxt_busy  = 1'b0;
         nxt_done  = 1'b0;
         nxt_dcnt  = '0;
         nxt_scnt  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         freq_word  <= '0;
         phase_clr  <= 1'b0;
         dds_en     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         sweep_idx  <= '0;
         dwell_cnt  <= '0;
         settle_cnt <= '0;
`ifdef DDS_SWEEP_PINGPONG_EN
         dir        <= 1'b0;
`endif
      end else begin
         state      <= nxt_state;
         freq_word  <= nxt_fw;
         phase_clr  <= nxt_pclr;
         dds_en     <= nxt_en;
         busy       <= nxt_busy;
         done       <= nxt_done;
         sweep_idx  <= nxt_idx;
         dwell_cnt  <= nxt_dcnt;
         settle_cnt <= nxt_scnt;
`ifdef DDS_SWEEP_PINGPONG_EN
         dir        <= nxt_dir;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_start  <= '0;
         c_stop   <= '0;
         c_step   <= '0;
         c_dwell  <= '0;
         c_sweeps <= '0;
      end else if (accept) begin
         c_start  <= cfg_f_start;
         c_stop   <= cfg_f_stop;
         c_step   <= cfg_f_step;
         c_dwell  <= cfg_dwell;
         c_sweeps <= cfg_sweeps;
      end
   end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: expected tuning words (one per dds_en
// cycle) and expected sweep_idx at done are queued by the stimulus; a monitor
// on the falling edge pops and compares whenever the DUT presents them.
module tb_dds_sweep_ctrl;
   localparam int FW = 32, DW = 16, CW = 8;

   logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
   logic [FW-1:0] cfg_f_start = '0, cfg_f_stop = '0, cfg_f_step = '0;
   logic [DW-1:0] cfg_dwell = '0;
   logic [CW-1:0] cfg_sweeps = '0;
   logic [FW-1:0] freq_word;
   logic          phase_clr, dds_en, busy, done;
   logic [CW-1:0] sweep_idx;

   dds_sweep_ctrl #(.FW(FW), .DW(DW), .CW(CW), .SETTLE(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .cfg_f_start(cfg_f_start), .cfg_f_stop(cfg_f_stop), .cfg_f_step(cfg_f_step),
      .cfg_dwell(cfg_dwell), .cfg_sweeps(cfg_sweeps),
      .freq_word(freq_word), .phase_clr(phase_clr), .dds_en(dds_en),
      .busy(busy), .done(done), .sweep_idx(sweep_idx)
   );

   always #5 clk = ~clk;

   int n_pass = 0, n_total = 0;
   logic [FW-1:0] fw_q[$];
   int            done_q[$];

   function automatic void chk(string name, longint act, longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endfunction

   // monitor / scoreboard
   always @(negedge clk) begin
      if (dds_en) begin
         if (fw_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected dds_en: got freq_word %0h, expected none", freq_word);
         end else chk("freq_word", freq_word, fw_q.pop_front());
      end
      if (done) begin
         if (done_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected done: got sweep_idx %0d, expected no done", sweep_idx);
         end else chk("done sweep_idx", sweep_idx, done_q.pop_front());
      end
   end

   task automatic set_cfg(input logic [FW-1:0] s, input logic [FW-1:0] p,
                          input logic [FW-1:0] st, input logic [DW-1:0] d,
                          input logic [CW-1:0] n);
      cfg_f_start = s; cfg_f_stop = p; cfg_f_step = st; cfg_dwell = d; cfg_sweeps = n;
   endtask

   task automatic push_word(input logic [FW-1:0] w, input int reps);
      for (int i = 0; i < reps; i++) fw_q.push_back(w);
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      chk(name, busy, 0);
   endtask

   task automatic drain(input string name);
      @(negedge clk);
      chk({name, " words left"}, fw_q.size(), 0);
      chk({name, " dones left"}, done_q.size(), 0);
   endtask

   initial begin
      // reset state
      #1;
      chk("rst freq_word", freq_word, 0);
      chk("rst busy", busy, 0);
      chk("rst dds_en", dds_en, 0);
      chk("rst phase_clr", phase_clr, 0);
      chk("rst sweep_idx", sweep_idx, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // basic sweep, also start-while-busy and cfg change mid-run
      set_cfg(100, 130, 10, 2, 2);
`ifdef DDS_SWEEP_PINGPONG_EN
      push_word(100, 3); push_word(110, 3); push_word(120, 3); push_word(130, 3);
      push_word(120, 3); push_word(110, 3); push_word(100, 3);
`else
      for (int k = 0; k < 2; k++) begin
         push_word(100, 3); push_word(110, 3); push_word(120, 3); push_word(130, 3);
      end
`endif
      done_q.push_back(2);
      pulse_start();
      chk("clear phase_clr", phase_clr, 1);
      chk("clear freq_word", freq_word, 100);
      chk("clear busy", busy, 1);
      chk("clear dds_en", dds_en, 0);
      @(negedge clk);
      chk("settle1 dds_en", dds_en, 0);
      chk("settle1 phase_clr", phase_clr, 0);
      @(negedge clk);
      chk("settle2 dds_en", dds_en, 0);
      set_cfg(7, 9999, 1, 0, 1);
      pulse_start();
      wait_idle("basic timeout", 100);
      chk("basic idle freq_word", freq_word, 0);
      chk("basic sweep_idx", sweep_idx, 2);
      repeat (3) @(negedge clk);
      chk("start not queued", busy, 0);
      chk("sweep_idx held", sweep_idx, 2);
      drain("basic");

      // carry at top of range ends the sweep after one word
      set_cfg(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10, 0, 1);
      push_word(32'hFFFF_FFF0, 1);
      done_q.push_back(1);
      pulse_start();
      wait_idle("carry timeout", 50);
      drain("carry");

      // zero step: one word per sweep
      set_cfg(50, 60, 0, 1, 3);
      push_word(50, 6);
      done_q.push_back(3);
      pulse_start();
      wait_idle("step0 timeout", 50);
      drain("step0");

      // start above stop
      set_cfg(200, 100, 5, 0, 2);
      push_word(200, 1);
`ifdef DDS_SWEEP_PINGPONG_EN
      push_word(195, 1);
`else
      push_word(200, 1);
`endif
      done_q.push_back(2);
      pulse_start();
      wait_idle("start>stop timeout", 50);
      drain("start>stop");

      // start and abort together in IDLE
      @(negedge clk); start = 1'b1; abort = 1'b1;
      @(negedge clk); start = 1'b0; abort = 1'b0;
      chk("start+abort busy", busy, 0);
      chk("start+abort phase_clr", phase_clr, 0);

      // continuous run, sweep_idx wrap, then abort
      set_cfg(5, 6, 1, 0, 0);
      for (int i = 0; i < 300; i++) begin push_word(5, 1); push_word(6, 1); end
      pulse_start();
      begin
         bit hit = 1'b0;
         for (int i = 0; i < 2000; i++) begin
            @(negedge clk); #1;
            if (fw_q.size() == 88) begin hit = 1'b1; break; end
         end
         chk("cont reached 256 sweeps", hit, 1);
         chk("cont idx before wrap", sweep_idx, 255);
         @(negedge clk); #1;
         chk("cont idx wrapped", sweep_idx, 0);
         hit = 1'b0;
         for (int i = 0; i < 500; i++) begin
            if (fw_q.size() == 0) begin hit = 1'b1; break; end
            @(negedge clk); #1;
         end
         chk("cont drained", hit, 1);
      end
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      chk("abort dds_en", dds_en, 0);
      chk("abort freq_word", freq_word, 0);
      chk("abort busy", busy, 0);
      chk("abort done", done, 0);
      drain("cont");

      // asynchronous reset in the middle of DWELL
      set_cfg(100, 130, 10, 2, 2);
      push_word(100, 3); push_word(110, 3);
      pulse_start();
      repeat (5) @(negedge clk);
      chk("pre-reset dds_en", dds_en, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async rst dds_en", dds_en, 0);
      chk("async rst freq_word", freq_word, 0);
      chk("async rst busy", busy, 0);
      chk("async rst sweep_idx", sweep_idx, 0);
      fw_q.delete();
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("post-reset busy", busy, 0);
      chk("post-reset freq_word", freq_word, 0);
      drain("reset");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Sequencer for the sine DDS path: phase-address generator, then 1-cycle-latency sine ROM, then dds_en output gate.
- Drives the frequency tuning word, phase-clear and output-enable of that path to run programmable frequency sweeps.
- Each sweep steps from a start word to a stop word with a fixed step and a programmable dwell per step.
- Sits between the control/register logic and the DDS instance, with a start/busy/done handshake toward control.

Parameters:
FW, 32, tuning-word width (freq_word, cfg_f_*)
DW, 16, dwell counter width
CW, 8, sweep counter width
SETTLE, 2, cycles dds_en is held low after phase clear (ROM + gate pipeline fill); legal range 1..15

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
start  in  1  single-cycle request; accepted only in IDLE
abort  in  1  stop the sequence immediately; priority over start
cfg_f_start  in  FW  first tuning word of each sweep
cfg_f_stop  in  FW  last allowed tuning word (inclusive)
cfg_f_step  in  FW  increment per step
cfg_dwell  in  DW  cycles per step minus 1
cfg_sweeps  in  CW  number of sweeps; 0 = run until abort
freq_word  out  FW  tuning word to the DDS phase accumulator
phase_clr  out  1  one-cycle phase-accumulator clear
dds_en  out  1  DDS output enable
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when all sweeps have completed
sweep_idx  out  CW  number of completed sweeps in the current run

Behaviour:
- Reset (async, rst_n=0): state IDLE; freq_word=0, phase_clr=0, dds_en=0, busy=0, done=0, sweep_idx=0; all internal counters 0.
- All outputs are registered. cfg_* is latched on start acceptance; later cfg changes have no effect until the next start.
- IDLE: freq_word=0, dds_en=0. start=1 and abort=0 → CLEAR.
- CLEAR (1 cycle): phase_clr=1, freq_word=cfg_f_start, sweep_idx=0, busy=1, dds_en=0 → SETTLE.
- SETTLE (SETTLE cycles): dds_en=0, phase_clr=0 → DWELL.
- DWELL: dds_en=1. Each tuning word is held cfg_dwell+1 cycles; dwell=0 gives 1 cycle per word.
- At the end of a dwell, compute next = freq_word + cfg_f_step in FW+1 bits.
  - next ≤ cfg_f_stop with no carry: freq_word=next.
  - Otherwise the sweep ends and sweep_idx increments.
    - cfg_sweeps≠0 and new sweep_idx == cfg_sweeps → FINISH.
    - Else freq_word=cfg_f_start and stay in DWELL; no phase clear, no settle.
- sweep_idx wraps modulo 2^CW when cfg_sweeps=0.
- Degenerate configurations each give one word per sweep, held at cfg_f_start:
  - cfg_f_step=0
  - cfg_f_start > cfg_f_stop
- FINISH (1 cycle): done=1, dds_en=0, freq_word held → IDLE, where freq_word=0. sweep_idx is held until the next start.
- abort=1 in any non-IDLE state → IDLE next cycle: dds_en=0, freq_word=0, done not pulsed. abort in IDLE has no effect.
- start while busy: ignored, not queued.
- Reset mid-operation: immediate return to reset values; no done.

Optional Feature:
DDS_SWEEP_PINGPONG_EN
- Defined:
  - A direction bit flips at each sweep end instead of reloading cfg_f_start.
  - Down legs use next = freq_word - cfg_f_step; a down leg ends when next < cfg_f_start or on borrow.
  - Each leg counts as one sweep.
  - On a flip, the first word of the new leg is the current word ± step.
  - Direction resets to up on CLEAR and on reset.
- Undefined: sawtooth behaviour as above; no direction register.

Test Plan:
- Reset: rst_n=0 asserted mid-DWELL → all outputs 0 asynchronously; after release busy=0, freq_word=0.
- Basic sweep, cfg start=100, stop=130, step=10, dwell=2, sweeps=2, SETTLE=2:
  - phase_clr pulse, then 2 cycles dds_en=0.
  - freq_word 100,110,120,130 each 3 cycles, repeated twice (24 cycles dds_en=1).
  - done one cycle later; busy falls the cycle after; sweep_idx=2.
- Boundary, start=0xFFFFFFF0, stop=0xFFFFFFFF, step=0x10, dwell=0, sweeps=1 → one word (carry ends the sweep); done after 1 DWELL cycle.
- Continuous, sweeps=0, start=5, stop=6, step=1, dwell=0:
  - freq_word alternates 5,6.
  - sweep_idx wraps 255→0.
  - abort → next cycle dds_en=0, freq_word=0, no done.
- Handshake: start during busy → ignored; start+abort same cycle in IDLE → stays IDLE; cfg change mid-run → no effect.
- DDS_SWEEP_PINGPONG_EN, start=100, stop=130, step=10, dwell=0, sweeps=2 → freq_word 100,110,120,130,120,110,100, then done.
